// File: rtl/pcsr_pkg.sv
// Shared constants and helpers for the PCSR overlap-add and column-collector stages.
// Both stages take COLS_PER_ROW from cols_per_row() so they agree on row length.
package pcsr_pkg;

    localparam int unsigned DEF_PIX_WIDTH       = 8;
    localparam int unsigned DEF_SIZE_OF_INPUT   = 5;
    localparam int unsigned DEF_SIZE_OF_FEATURE = 2;
    localparam int unsigned DEF_SIZE_OF_WEIGHT  = 5;
    localparam int unsigned DEF_STRIDE          = 2;
    localparam int unsigned DEF_ROWS_PER_FRAME  = 4;
    localparam int unsigned DEF_FIFO_DEPTH      = 8;

    // Framing markers that travel alongside each output column
    typedef struct packed {
        logic row_last;
        logic frame_last;
    } col_tag_t;

    // Output columns per row of a transposed convolution
    function automatic int unsigned cols_per_row(input int unsigned size_of_feature,
                                                 input int unsigned stride,
                                                 input int unsigned size_of_weight);
        return (size_of_feature - 1) * stride + size_of_weight;
    endfunction

endpackage

// File: rtl/pcsr_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered fill count.
// The caller must not push when full unless it pops in the same cycle.
module pcsr_sync_fifo #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic                       valid_o,
    output logic                       full_o,
    output logic [$clog2(DEPTH):0]     fill_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [FW-1:0]    fill;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   fill <= fill + FW'(1);
                2'b01:   fill <= fill - FW'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage carries no reset; contents are only observed while occupied
    always_ff @(posedge clk_i) begin
        if (push_i && !clear_i) mem[wr_ptr] <= data_i;
    end

    assign data_o  = mem[rd_ptr];
    assign valid_o = (fill != '0);
    assign full_o  = (fill == FW'(DEPTH));
    assign fill_o  = fill;

endmodule

// File: rtl/pcsr_column_collector.sv
// Buffers overlap-added output columns and re-emits them on valid/ready,
// tagged with row/frame end markers and a sticky drop flag.
module pcsr_column_collector
    import pcsr_pkg::*;
#(
    parameter int unsigned PIX_WIDTH       = DEF_PIX_WIDTH,
    parameter int unsigned SIZE_OF_INPUT   = DEF_SIZE_OF_INPUT,
    parameter int unsigned SIZE_OF_FEATURE = DEF_SIZE_OF_FEATURE,
    parameter int unsigned SIZE_OF_WEIGHT  = DEF_SIZE_OF_WEIGHT,
    parameter int unsigned STRIDE          = DEF_STRIDE,
    parameter int unsigned ROWS_PER_FRAME  = DEF_ROWS_PER_FRAME,
    parameter int unsigned FIFO_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                clear_i,
    input  logic                                valid_i,
    input  logic [SIZE_OF_INPUT*PIX_WIDTH-1:0]  buffer_i,
    input  logic                                ready_i,
    output logic                                valid_o,
    output logic [SIZE_OF_INPUT*PIX_WIDTH-1:0]  buffer_o,
    output logic                                row_last_o,
    output logic                                frame_last_o,
    output logic [$clog2(FIFO_DEPTH):0]         fill_o,
    output logic                                overflow_o
);

    localparam int unsigned COL_BITS     = SIZE_OF_INPUT * PIX_WIDTH;
    localparam int unsigned COLS_PER_ROW = cols_per_row(SIZE_OF_FEATURE, STRIDE, SIZE_OF_WEIGHT);
    localparam int unsigned CW = (COLS_PER_ROW   > 1) ? $clog2(COLS_PER_ROW)   : 1;
    localparam int unsigned RW = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1;

    logic                push_c;
    logic                pop_c;
    logic                fifo_valid;
    logic                fifo_full;
    logic [COL_BITS-1:0] fifo_data;
    logic [CW-1:0]       col_cnt;
    logic [RW-1:0]       row_cnt;
    logic                overflow;
    col_tag_t            tag_c;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts then
    assign pop_c  = fifo_valid && ready_i;
    assign push_c = valid_i && (!fifo_full || pop_c);

    pcsr_sync_fifo #(
        .WIDTH (COL_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear_i (clear_i),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .data_i  (buffer_i),
        .data_o  (fifo_data),
        .valid_o (fifo_valid),
        .full_o  (fifo_full),
        .fill_o  (fill_o)
    );

    // Sticky drop flag
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow <= 1'b0;
        end else if (clear_i) begin
            overflow <= 1'b0;
        end else if (valid_i && !push_c) begin
            overflow <= 1'b1;
        end
    end

    // Framing counters advance only on accepted output columns
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (clear_i) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (pop_c) begin
            if (col_cnt == CW'(COLS_PER_ROW - 1)) begin
                col_cnt <= '0;
                if (row_cnt == RW'(ROWS_PER_FRAME - 1)) row_cnt <= '0;
                else                                    row_cnt <= row_cnt + RW'(1);
            end else begin
                col_cnt <= col_cnt + CW'(1);
            end
        end
    end

    always_comb begin
        tag_c            = '0;
        tag_c.row_last   = fifo_valid && (col_cnt == CW'(COLS_PER_ROW - 1));
        tag_c.frame_last = tag_c.row_last && (row_cnt == RW'(ROWS_PER_FRAME - 1));
    end

    // Memory is not reset, so gate the head word to keep buffer_o at 0 when idle
    assign valid_o      = fifo_valid;
    assign buffer_o     = fifo_valid ? fifo_data : '0;
    assign row_last_o   = tag_c.row_last;
    assign frame_last_o = tag_c.frame_last;
    assign overflow_o   = overflow;

endmodule

// File: tb/tb_pcsr_column_collector.sv
// Directed bench for pcsr_column_collector at default parameters.
module tb_pcsr_column_collector;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic        valid_i;
    logic [39:0] buffer_i;
    logic        ready_i;
    logic        valid_o;
    logic [39:0] buffer_o;
    logic        row_last_o;
    logic        frame_last_o;
    logic [3:0]  fill_o;
    logic        overflow_o;

    int n_tests = 0;
    int n_fail  = 0;

    pcsr_column_collector dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .valid_i      (valid_i),
        .buffer_i     (buffer_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .buffer_o     (buffer_o),
        .row_last_o   (row_last_o),
        .frame_last_o (frame_last_o),
        .fill_o       (fill_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_i    = 1'b0;
        clear_i  = 1'b0;
        valid_i  = 1'b0;
        buffer_i = '0;
        ready_i  = 1'b0;
        tick();
        tick();
        chk("rst_valid",    64'(valid_o),      64'd0);
        chk("rst_buffer",   64'(buffer_o),     64'd0);
        chk("rst_row_last", 64'(row_last_o),   64'd0);
        chk("rst_frm_last", 64'(frame_last_o), 64'd0);
        chk("rst_fill",     64'(fill_o),       64'd0);
        chk("rst_overflow", 64'(overflow_o),   64'd0);
        rst_i = 1'b1;
        tick();

        // Streaming: 28 columns, one full frame
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 1; i <= 28; i++) begin
            buffer_i = 40'(i);
            tick();
            chk($sformatf("stream_valid_%0d", i),    64'(valid_o),      64'd1);
            chk($sformatf("stream_data_%0d", i),     64'(buffer_o),     64'(i));
            chk($sformatf("stream_row_last_%0d", i), 64'(row_last_o),   64'(i % 7 == 0));
            chk($sformatf("stream_frm_last_%0d", i), 64'(frame_last_o), 64'(i == 28));
            chk($sformatf("stream_ovf_%0d", i),      64'(overflow_o),   64'd0);
        end
        valid_i = 1'b0;
        tick();
        chk("stream_drained_valid", 64'(valid_o), 64'd0);
        chk("stream_drained_fill",  64'(fill_o),  64'd0);

        // Backpressure: fill to 8, drop the 9th
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            buffer_i = 40'(i);
            tick();
        end
        chk("bp_fill_8",     64'(fill_o),     64'd8);
        chk("bp_ovf_before", 64'(overflow_o), 64'd0);
        buffer_i = 40'd9;
        tick();
        valid_i = 1'b0;
        chk("bp_ovf_after",  64'(overflow_o), 64'd1);
        chk("bp_fill_after", 64'(fill_o),     64'd8);
        ready_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("bp_drain_%0d", i),    64'(buffer_o),   64'(i));
            chk($sformatf("bp_row_last_%0d", i), 64'(row_last_o), 64'(i == 7));
            tick();
        end
        chk("bp_empty", 64'(valid_o), 64'd0);
        chk("bp_ovf_sticky", 64'(overflow_o), 64'd1);

        // Soft clear to restart framing and overflow
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        chk("clr1_ovf",  64'(overflow_o), 64'd0);
        chk("clr1_fill", 64'(fill_o),     64'd0);

        // Full plus simultaneous push and pop
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            buffer_i = 40'(32'h20 + i);
            tick();
        end
        chk("fs_fill_8", 64'(fill_o), 64'd8);
        ready_i  = 1'b1;
        buffer_i = 40'h29;
        tick();
        valid_i = 1'b0;
        chk("fs_fill_still_8", 64'(fill_o),     64'd8);
        chk("fs_ovf",          64'(overflow_o), 64'd0);
        for (int i = 2; i <= 9; i++) begin
            chk($sformatf("fs_drain_%0d", i), 64'(buffer_o), 64'(32'h20 + i));
            tick();
        end
        chk("fs_empty", 64'(valid_o), 64'd0);

        // Stall hold: 9 pops since clear, col_cnt = 2
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        buffer_i = 40'hAABBCCDDEE;
        tick();
        valid_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("hold_data_%0d", i),     64'(buffer_o),   64'hAABBCCDDEE);
            chk($sformatf("hold_row_last_%0d", i), 64'(row_last_o), 64'd0);
            chk($sformatf("hold_fill_%0d", i),     64'(fill_o),     64'd1);
        end
        ready_i = 1'b1;
        tick();
        chk("hold_released", 64'(valid_o), 64'd0);

        // Soft clear setup: 10 pops so far -> col_cnt 3
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            buffer_i = 40'(32'h30 + i);
            tick();
        end
        valid_i = 1'b0;
        chk("sc_ovf_set", 64'(overflow_o), 64'd1);
        ready_i = 1'b1;
        repeat (8) tick();
        valid_i  = 1'b1;
        buffer_i = 40'h3A;
        tick();
        valid_i = 1'b0;
        tick();
        // 19 pops -> col_cnt 5; now hold 3 columns
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            buffer_i = 40'(32'h40 + i);
            tick();
        end
        chk("sc_pre_fill",     64'(fill_o),     64'd3);
        chk("sc_pre_ovf",      64'(overflow_o), 64'd1);
        chk("sc_pre_row_last", 64'(row_last_o), 64'd0);
        clear_i  = 1'b1;
        buffer_i = 40'h99;
        tick();
        clear_i = 1'b0;
        valid_i = 1'b0;
        chk("sc_fill",  64'(fill_o),     64'd0);
        chk("sc_ovf",   64'(overflow_o), 64'd0);
        chk("sc_valid", 64'(valid_o),    64'd0);
        tick();
        chk("sc_push_ignored", 64'(valid_o), 64'd0);
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            buffer_i = 40'(32'h50 + i);
            tick();
            chk($sformatf("sc_data_%0d", i),     64'(buffer_o),   64'(32'h50 + i));
            chk($sformatf("sc_row_last_%0d", i), 64'(row_last_o), 64'(i == 7));
        end
        valid_i = 1'b0;
        tick();

        // Async reset mid-cycle with 4 held columns
        ready_i = 1'b0;
        valid_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            buffer_i = 40'(32'h60 + i);
            tick();
        end
        valid_i = 1'b0;
        chk("ar_pre_fill", 64'(fill_o), 64'd4);
        #2;
        rst_i = 1'b0;
        #1;
        chk("ar_valid",    64'(valid_o),      64'd0);
        chk("ar_buffer",   64'(buffer_o),     64'd0);
        chk("ar_row_last", 64'(row_last_o),   64'd0);
        chk("ar_frm_last", 64'(frame_last_o), 64'd0);
        chk("ar_fill",     64'(fill_o),       64'd0);
        chk("ar_ovf",      64'(overflow_o),   64'd0);
        #2;
        rst_i = 1'b1;
        tick();
        chk("ar_post_valid", 64'(valid_o), 64'd0);
        ready_i = 1'b1;
        valid_i = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            buffer_i = 40'(32'h70 + i);
            tick();
            chk($sformatf("ar_data_%0d", i),     64'(buffer_o),   64'(32'h70 + i));
            chk($sformatf("ar_row_last_%0d", i), 64'(row_last_o), 64'(i == 7));
        end
        valid_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pcsr_column_collector.md
Name: pcsr_column_collector

Overview:
- Downstream stage of the overlap-add column unit. Receives overlap-added output columns (SIZE_OF_INPUT pixels each) as a valid-only stream with no backpressure.
- Buffers columns in a small FIFO and re-emits them on a valid/ready interface to the feature-map writer.
- Tags each column with row-end and frame-end markers and flags any column dropped because the FIFO was full.

Parameters:
- PIX_WIDTH, 8, bits per pixel.
- SIZE_OF_INPUT, 5, pixels per column vector.
- SIZE_OF_FEATURE, 2, input feature columns per row.
- SIZE_OF_WEIGHT, 5, kernel width.
- STRIDE, 2, transposed-conv stride.
- ROWS_PER_FRAME, 4, output rows per frame.
- FIFO_DEPTH, 8, column entries; power of two, at least 2.
- Derived constant COLS_PER_ROW = (SIZE_OF_FEATURE-1)*STRIDE + SIZE_OF_WEIGHT, which is 7 at defaults.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-low.
- clear_i  in  1  synchronous soft clear: empties the FIFO, zeroes the counters, clears overflow_o.
- valid_i  in  1  column present on buffer_i.
- buffer_i  in  SIZE_OF_INPUT*PIX_WIDTH  column from upstream.
- ready_i  in  1  downstream can accept.
- valid_o  out  1  column available.
- buffer_o  out  SIZE_OF_INPUT*PIX_WIDTH  column to downstream.
- row_last_o  out  1  current output column is the last of its row.
- frame_last_o  out  1  current output column is the last of the frame.
- fill_o  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow_o  out  1  sticky: at least one column was dropped.

Behaviour:
- Reset: every output is 0, both pointers are 0, column and row counters are 0, memory contents are don't-care.
- Push: push = valid_i && (fill < FIFO_DEPTH || pop).
  - When valid_i is high and the FIFO is full with no pop, the column is discarded and overflow_o is set on the next edge.
  - overflow_o stays high until reset or clear_i.
- Pop: pop = valid_o && ready_i.
  - Data is first-word-fall-through: buffer_o = mem[rd_ptr] whenever valid_o is high.
  - buffer_o is held stable while valid_o && !ready_i.
- Latency: a push into an empty FIFO raises valid_o on the next cycle. There is no combinational bypass from valid_i to valid_o.
- Simultaneous push and pop:
  - fill is unchanged and both pointers advance.
  - When full, the push is accepted because the pop frees the slot.
  - When empty, a pop is impossible because valid_o is 0.
- Pointers: wrap modulo FIFO_DEPTH. fill_o is registered, +1 on push-only, -1 on pop-only.
- Column counter (col_cnt):
  - Range 0..COLS_PER_ROW-1; advances only on pop.
  - row_last_o = valid_o && col_cnt == COLS_PER_ROW-1.
  - On a pop at COLS_PER_ROW-1, col_cnt wraps to 0 and row_cnt advances.
- Row counter (row_cnt):
  - Range 0..ROWS_PER_FRAME-1.
  - frame_last_o = row_last_o && row_cnt == ROWS_PER_FRAME-1.
  - A pop with frame_last_o wraps both counters to 0.
- clear_i: has priority over push and pop in the same cycle. Zeroes fill, both pointers, both counters and overflow_o; valid_o is 0 from the next cycle.
- Reset mid-transfer: any held column is lost and no partial state survives. Downstream must treat reset as a frame abort.
- Arithmetic: none on pixel data. Columns pass bit-exact; the upstream stage has already handled saturation and scaling.

Decomposition:
- Shared package (pcsr_pkg): PIX_WIDTH, SIZE_OF_INPUT, SIZE_OF_FEATURE, SIZE_OF_WEIGHT, STRIDE defaults, plus a function returning COLS_PER_ROW. The package is shared with the overlap-add stage so both agree on row length.
- One sub-module: pcsr_sync_fifo.
  - Parameterised width and depth.
  - FWFT, with fill count and full/empty.
- The top level holds push/pop qualification, the overflow flag and the column/row framing counters.

Test Plan:
- Streaming: defaults, ready_i=1, valid_i=1 for 28 cycles with columns 0x0000000001..0x000000001C.
  - Outputs appear in order, 1 cycle after input.
  - row_last_o on outputs 7, 14, 21, 28; frame_last_o only on output 28.
  - overflow_o stays 0.
- Backpressure: ready_i=0, push 8 columns (fill_o=8), push a 9th.
  - The 9th is dropped and overflow_o=1.
  - Raising ready_i drains exactly columns 1..8.
- Full plus simultaneous: with fill_o=8 and ready_i=1, push one column in the same cycle.
  - Push is accepted, fill_o stays 8, overflow_o stays 0, and the new column emerges 8th in order.
- Stall hold: valid_o=1 with buffer_o=0xAABBCCDDEE and ready_i=0 for 5 cycles.
  - buffer_o, row_last_o and fill_o are unchanged throughout.
- Soft clear: with fill_o=3, col_cnt=5 and overflow_o=1, pulse clear_i together with valid_i.
  - The pushed column is ignored and fill_o=0, overflow_o=0.
  - The next row_last_o appears after 7 fresh pops.
- Async reset: assert rst_i low mid-cycle with fill_o=4.
  - All outputs are 0 immediately.
  - After release, the first pushed column appears with col_cnt=0.
